tb_mailbox: RTL and testbench

- Bus responder that occupies one chip-enable slot of the tb_ctl debug bus, the slave side of the ce/we/addr/wd/bytesel/rd protocol.
- Provides a two-direction mailbox between the host (over the bus) and fabric logic (over valid/ready streams).
- TX FIFO: bus writes push, fabric pops. RX FIFO: fabric pushes, bus reads pop.
- Status, threshold and ID registers are memory-mapped alongside the data port.

---
 rtl/tb_mailbox.sv | 228 ++++++++++++++++++++++
 tb/tb_tb_mailbox.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_mailbox.sv
// Host/fabric mailbox on one tb_ctl bus slot: TX FIFO (bus push, stream pop), RX FIFO (stream push, bus pop).
// rd is registered (1 cycle); streams use valid/ready. `define MBOX_IRQ_EN adds THRESH compare and the irq output.

module tb_mailbox_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic        i_pop,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_head,
  output logic        o_full,
  output logic        o_empty,
  output logic [7:0]  o_count
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [7:0]    r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_count_nxt;

  // Acceptance looks only at the registered flags, so a full FIFO refuses a push even if it pops this cycle.
  assign w_push = i_push && !r_full && !i_flush;
  assign w_pop  = i_pop && !r_empty && !i_flush;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 8'd1;
      2'b01:   w_count_nxt = r_count - 8'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= 8'd0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == 8'(DEPTH));
      r_empty <= (w_count_nxt == 8'd0);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

module tb_mailbox #(
  parameter int          DEPTH = 16,
  parameter logic [31:0] ID    = 32'h4D42_0001
) (
  input  logic        sysclk,
  input  logic        sys_rst,
  input  logic        ce,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wd,
  input  logic [3:0]  bytesel,
  output logic [31:0] rd,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready
`ifdef MBOX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_THRESH = 2'd2;
  localparam logic [1:0] A_ID     = 2'd3;

  logic        w_rd_acc;
  logic        w_wr_acc;
  logic        w_tx_push_req;
  logic        w_rx_pop_req;
  logic        w_stat_wr;
  logic        w_tx_flush;
  logic        w_rx_flush;
  logic        w_ovf_set;
  logic        w_udf_set;
  logic        w_ovf_clr;
  logic        w_udf_clr;
  logic [31:0] w_tx_head;
  logic [31:0] w_rx_head;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic [7:0]  w_tx_count;
  logic [7:0]  w_rx_count;
  logic [31:0] w_status;
  logic [31:0] w_thresh_rd;
  logic        r_tx_ovf;
  logic        r_rx_udf;
  logic [31:0] r_rd;

  assign w_rd_acc      = ce && !we;
  assign w_wr_acc      = ce && we;
  assign w_tx_push_req = w_wr_acc && (addr == A_DATA) && (bytesel == 4'hF);
  assign w_rx_pop_req  = w_rd_acc && (addr == A_DATA);
  assign w_stat_wr     = w_wr_acc && (addr == A_STATUS);
  assign w_tx_flush    = w_stat_wr && bytesel[1] && wd[8];
  assign w_rx_flush    = w_stat_wr && bytesel[1] && wd[9];
  assign w_ovf_clr     = w_stat_wr && bytesel[0] && wd[4];
  assign w_udf_clr     = w_stat_wr && bytesel[0] && wd[5];
  assign w_ovf_set     = w_tx_push_req && w_tx_full;
  assign w_udf_set     = w_rx_pop_req && w_rx_empty;

  tb_mailbox_fifo #(.DEPTH(DEPTH)) u_tx (
    .i_clk   (sysclk),
    .i_rst   (sys_rst),
    .i_flush (w_tx_flush),
    .i_push  (w_tx_push_req),
    .i_pop   (out_ready),
    .i_wdata (wd),
    .o_head  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  tb_mailbox_fifo #(.DEPTH(DEPTH)) u_rx (
    .i_clk   (sysclk),
    .i_rst   (sys_rst),
    .i_flush (w_rx_flush),
    .i_push  (in_valid),
    .i_pop   (w_rx_pop_req),
    .i_wdata (in_data),
    .o_head  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  assign out_data  = w_tx_head;
  assign out_valid = !w_tx_empty;
  assign in_ready  = !w_rx_full;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      r_tx_ovf <= 1'b0;
      r_rx_udf <= 1'b0;
    end else begin
      r_tx_ovf <= w_ovf_set || (r_tx_ovf && !w_ovf_clr);
      r_rx_udf <= w_udf_set || (r_rx_udf && !w_udf_clr);
    end
  end

`ifdef MBOX_IRQ_EN
  logic [7:0] r_thresh;
  logic       r_irq;

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      r_thresh <= 8'd0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_acc && (addr == A_THRESH) && bytesel[0]) r_thresh <= wd[7:0];
      r_irq <= ((r_thresh != 8'd0) && (w_rx_count >= r_thresh)) || r_tx_ovf || r_rx_udf;
    end
  end

  assign irq         = r_irq;
  assign w_thresh_rd = {24'd0, r_thresh};
`else
  assign w_thresh_rd = 32'd0;
`endif

  always_comb begin
    w_status        = 32'd0;
    w_status[0]     = w_rx_empty;
    w_status[1]     = w_rx_full;
    w_status[2]     = w_tx_empty;
    w_status[3]     = w_tx_full;
    w_status[4]     = r_tx_ovf;
    w_status[5]     = r_rx_udf;
    w_status[15:8]  = w_rx_count;
    w_status[23:16] = w_tx_count;
`ifdef MBOX_IRQ_EN
    w_status[24]    = r_irq;
`endif
  end

  always_ff @(posedge sysclk) begin
    if (sys_rst) begin
      r_rd <= 32'd0;
    end else if (w_rd_acc) begin
      case (addr)
        A_DATA:   r_rd <= w_rx_empty ? 32'd0 : w_rx_head;
        A_STATUS: r_rd <= w_status;
        A_THRESH: r_rd <= w_thresh_rd;
        A_ID:     r_rd <= ID;
        default:  r_rd <= 32'd0;
      endcase
    end
  end

  assign rd = r_rd;

endmodule

// File: tb/tb_tb_mailbox.sv
// Random and directed traffic against a queue-based mailbox model; literal checks pin the model.
module tb_tb_mailbox;

  localparam int          DEPTH = 16;
  localparam logic [31:0] ID    = 32'h4D42_0001;

  logic        sysclk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wd = 32'd0;
  logic [3:0]  bytesel = 4'd0;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
`ifdef MBOX_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  logic [31:0] m_rd = 32'd0;
  logic        m_ovf = 1'b0;
  logic        m_udf = 1'b0;
  logic [7:0]  m_th = 8'd0;
  logic        m_irq = 1'b0;

  tb_mailbox #(.DEPTH(DEPTH), .ID(ID)) dut (
    .sysclk    (sysclk),
    .sys_rst   (sys_rst),
    .ce        (ce),
    .we        (we),
    .addr      (addr),
    .wd        (wd),
    .bytesel   (bytesel),
    .rd        (rd),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready)
`ifdef MBOX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    int          txn = txq.size();
    int          rxn = rxq.size();
    logic [31:0] st;
    bit          ovf_set = 0, udf_set = 0, ovf_clr = 0, udf_clr = 0;
    bit          tx_flush = 0, rx_flush = 0, tx_push = 0, rx_pop = 0;
    bit          tx_pop, rx_push, irq_n;
    if (sys_rst) begin
      txq.delete(); rxq.delete();
      m_rd = 0; m_ovf = 0; m_udf = 0; m_th = 0; m_irq = 0;
      return;
    end
    st = 32'(rxn == 0) + 32'(rxn == DEPTH) * 2 + 32'(txn == 0) * 4 + 32'(txn == DEPTH) * 8
       + 32'(m_ovf) * 16 + 32'(m_udf) * 32 + (32'(rxn) << 8) + (32'(txn) << 16) + (32'(m_irq) << 24);
    irq_n = (m_th != 0 && rxn >= int'(m_th)) || m_ovf || m_udf;
    if (ce && !we) begin
      case (addr)
        2'd0: if (rxn > 0) begin m_rd = rxq[0]; rx_pop = 1; end
              else begin m_rd = 0; udf_set = 1; end
        2'd1: m_rd = st;
        2'd2: m_rd = {24'd0, m_th};
        default: m_rd = ID;
      endcase
    end else if (ce && we) begin
      if (addr == 2'd0 && bytesel == 4'hF) begin
        if (txn == DEPTH) ovf_set = 1; else tx_push = 1;
      end
      if (addr == 2'd1) begin
        ovf_clr  = bytesel[0] && wd[4];
        udf_clr  = bytesel[0] && wd[5];
        tx_flush = bytesel[1] && wd[8];
        rx_flush = bytesel[1] && wd[9];
      end
`ifdef MBOX_IRQ_EN
      if (addr == 2'd2 && bytesel[0]) m_th = wd[7:0];
`endif
    end
    tx_pop  = out_ready && txn > 0;
    rx_push = in_valid && rxn < DEPTH;
    if (tx_flush) txq.delete();
    else begin
      if (tx_pop) void'(txq.pop_front());
      if (tx_push) txq.push_back(wd);
    end
    if (rx_flush) rxq.delete();
    else begin
      if (rx_pop) void'(rxq.pop_front());
      if (rx_push) rxq.push_back(in_data);
    end
    m_ovf = ovf_set || (m_ovf && !ovf_clr);
    m_udf = udf_set || (m_udf && !udf_clr);
`ifdef MBOX_IRQ_EN
    m_irq = irq_n;
`else
    m_irq = 0;
`endif
  endtask

  task automatic compare();
    chk("rd", rd, m_rd);
    chk("out_valid", 32'(out_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) chk("out_data", out_data, txq[0]);
    chk("in_ready", 32'(in_ready), 32'(rxq.size() < DEPTH));
`ifdef MBOX_IRQ_EN
    chk("irq", 32'(irq), 32'(m_irq));
`endif
  endtask

  task automatic step();
    model_step();
    @(posedge sysclk);
    @(negedge sysclk);
    compare();
  endtask

  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    ce = 1'b1; we = w; addr = a; wd = d; bytesel = b;
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  initial begin
    int rdy_pct = 50;
    step(); step();
    chk("reset_rd", rd, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    sys_rst = 1'b0;
    step();

    bus(0, 2'd3, 0, 0);
    chk("id_read", rd, 32'h4D42_0001);
    bus(0, 2'd1, 0, 0);
    chk("status_reset", rd, 32'h0000_0005);
    bus(1, 2'd2, 32'h55, 4'h1);
    bus(0, 2'd2, 0, 0);
`ifdef MBOX_IRQ_EN
    chk("thresh_rb", rd, 32'h55);
    bus(1, 2'd2, 0, 4'h1);
`else
    chk("thresh_rb", rd, 32'h0);
`endif

    bus(1, 2'd0, 32'hCAFE0001, 4'hF);
    chk("tx_first_valid", 32'(out_valid), 32'd1);
    chk("tx_first_data", out_data, 32'hCAFE0001);
    bus(0, 2'd1, 0, 0);
    chk("tx_count_1", 32'(rd[23:16]), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("tx_popped", 32'(out_valid), 32'd0);

    for (int i = 0; i < 16; i++) bus(1, 2'd0, 32'h1000_0000 + 32'(i), 4'hF);
    bus(1, 2'd0, 32'h12345678, 4'hF);
    bus(0, 2'd1, 0, 0);
    chk("status_full_ovf", rd, 32'h0010_0019);
    bus(1, 2'd1, 32'h10, 4'h1);
    bus(0, 2'd1, 0, 0);
    chk("status_ovf_clr", rd, 32'h0010_0009);

    out_ready = 1'b1;
    bus(1, 2'd0, 32'hDEAD0000, 4'hF);
    out_ready = 1'b0;
    chk("head_after_pop", out_data, 32'h1000_0001);
    bus(0, 2'd1, 0, 0);
    chk("status_pop_drop", rd, 32'h000F_0011);
    bus(1, 2'd0, 32'hBEEF0000, 4'h3);
    bus(0, 2'd1, 0, 0);
    chk("status_partial_bs", rd, 32'h000F_0011);
    bus(1, 2'd1, 32'h110, 4'h3);
    bus(0, 2'd1, 0, 0);
    chk("status_tx_flushed", rd, 32'h0000_0005);

    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 32'hA0 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus(0, 2'd0, 0, 0);
      chk("rx_read", rd, 32'hA0 + 32'(i));
    end
    bus(0, 2'd0, 0, 0);
    chk("rx_underflow_rd", rd, 32'd0);
    chk("rx_in_ready", 32'(in_ready), 32'd1);
    bus(0, 2'd1, 0, 0);
    chk("status_udf", rd, 32'h0000_0025);
    bus(1, 2'd1, 32'h30, 4'h1);

`ifdef MBOX_IRQ_EN
    bus(1, 2'd2, 32'h2, 4'h1);
    in_valid = 1'b1;
    in_data = 32'h11; step();
    in_data = 32'h22; step();
    in_valid = 1'b0;
    step();
    chk("irq_thresh", 32'(irq), 32'd1);
    bus(0, 2'd0, 0, 0);
    step();
    chk("irq_below", 32'(irq), 32'd0);
    bus(1, 2'd1, 32'h300, 4'h2);
    bus(0, 2'd1, 0, 0);
    chk("status_flush_all", rd, 32'h0000_0005);
`endif

    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) rdy_pct = $urandom_range(10, 90);
      sys_rst   = ($urandom_range(0, 599) == 0);
      ce        = 1'($urandom_range(0, 1));
      we        = 1'($urandom_range(0, 1));
      addr      = 2'($urandom_range(0, 3));
      bytesel   = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
      wd        = $urandom;
      if (we && addr == 2'd1 && $urandom_range(0, 7) != 0) wd = wd & ~32'h330;
      if (we && addr == 2'd2) wd = wd & 32'h1F;
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      in_valid  = ($urandom_range(0, 99) >= rdy_pct);
      in_data   = $urandom;
      step();
    end
    sys_rst = 1'b0; ce = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
